// File: rtl/act_pwl_unit.sv
// Piecewise-linear activation stage: y = a*x + b per lane. The (a, b) pair comes from a
// writable 64-entry LUT indexed by the top bits of x. Three-stage valid/ready pipeline.
module act_pwl_unit #(
  parameter int NU_COUNT      = 4,
  parameter int Q_SIZE        = 16,
  parameter int Q_FRAC        = 12,
  parameter int ACT_LUT_DEPTH = 6,
  parameter int ACT_LUT_SIZE  = 32,
  parameter int ACT_MASK_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NU_COUNT*Q_SIZE-1:0] in_data,
  input  logic [ACT_MASK_SIZE-1:0]   in_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NU_COUNT*Q_SIZE-1:0] out_data,
  input  logic                       lut_we,
  input  logic [ACT_LUT_DEPTH-1:0]   lut_addr,
  input  logic [ACT_LUT_SIZE-1:0]    lut_wdata
);
  localparam int LUT_ENTRIES = 1 << ACT_LUT_DEPTH;
  localparam int P_W         = 2 * Q_SIZE;
  localparam logic [ACT_LUT_SIZE-1:0] LUT_IDENT = ACT_LUT_SIZE'(1) << (Q_SIZE + Q_FRAC);
  localparam logic signed [P_W-1:0]   RND       = P_W'(1) << (Q_FRAC - 1);
  localparam logic signed [P_W-1:0]   SAT_MAX   = P_W'((1 << (Q_SIZE - 1)) - 1);
  localparam logic signed [P_W-1:0]   SAT_MIN   = ~SAT_MAX;

  logic adv;

  logic [ACT_LUT_SIZE-1:0] lut_q [LUT_ENTRIES];
  logic [ACT_LUT_SIZE-1:0] lut_d [LUT_ENTRIES];

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
  logic [Q_SIZE-1:0]        s1_x_q    [NU_COUNT];
  logic [Q_SIZE-1:0]        s1_x_d    [NU_COUNT];
  logic [ACT_LUT_SIZE-1:0]  s1_coef_q [NU_COUNT];
  logic [ACT_LUT_SIZE-1:0]  s1_coef_d [NU_COUNT];
  logic [ACT_MASK_SIZE-1:0] s1_mask_q, s1_mask_d, s2_mask_q, s2_mask_d;
  logic [Q_SIZE-1:0]        s2_x_q    [NU_COUNT];
  logic [Q_SIZE-1:0]        s2_x_d    [NU_COUNT];
  logic signed [P_W-1:0]    s2_prod_q [NU_COUNT];
  logic signed [P_W-1:0]    s2_prod_d [NU_COUNT];
  logic signed [Q_SIZE-1:0] s2_b_q    [NU_COUNT];
  logic signed [Q_SIZE-1:0] s2_b_d    [NU_COUNT];
  logic [NU_COUNT*Q_SIZE-1:0] out_data_q, out_data_d;

  logic [Q_SIZE-1:0]       lane_x    [NU_COUNT];
  logic [ACT_LUT_SIZE-1:0] lane_coef [NU_COUNT];
  logic signed [P_W-1:0]   lane_prod [NU_COUNT];
  logic [Q_SIZE-1:0]       lane_y    [NU_COUNT];

  for (genvar gi = 0; gi < NU_COUNT; gi++) begin : g_lane
    logic signed [P_W-1:0] rnd_sum, shifted, sum;

    assign lane_x[gi]    = in_data[gi*Q_SIZE +: Q_SIZE];
    // Read the pre-edge LUT contents so a same-cycle write is not visible yet.
    assign lane_coef[gi] = lut_q[lane_x[gi][Q_SIZE-1 -: ACT_LUT_DEPTH]];
    assign lane_prod[gi] = P_W'($signed(s1_coef_q[gi][ACT_LUT_SIZE-1 -: Q_SIZE]))
                         * P_W'($signed(s1_x_q[gi]));

    // Round half up, then add b; the sum cannot overflow P_W so clamp on the wide value.
    assign rnd_sum = s2_prod_q[gi] + RND;
    assign shifted = rnd_sum >>> Q_FRAC;
    assign sum     = shifted + P_W'(s2_b_q[gi]);
    assign lane_y[gi] = s2_mask_q[gi]   ? s2_x_q[gi] :
                        (sum > SAT_MAX) ? SAT_MAX[Q_SIZE-1:0] :
                        (sum < SAT_MIN) ? SAT_MIN[Q_SIZE-1:0] :
                                          sum[Q_SIZE-1:0];
  end

  always_comb begin
    adv = !out_valid_q || out_ready;

    lut_d = lut_q;
    if (lut_we) lut_d[lut_addr] = lut_wdata;

    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_coef_d   = s1_coef_q;
    s1_mask_d   = s1_mask_q;
    s2_valid_d  = s2_valid_q;
    s2_x_d      = s2_x_q;
    s2_prod_d   = s2_prod_q;
    s2_b_d      = s2_b_q;
    s2_mask_d   = s2_mask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (adv) begin
      s1_valid_d  = in_valid;
      s1_mask_d   = in_mask;
      s2_valid_d  = s1_valid_q;
      s2_mask_d   = s1_mask_q;
      out_valid_d = s2_valid_q;
      for (int i = 0; i < NU_COUNT; i++) begin
        s1_x_d[i]    = lane_x[i];
        s1_coef_d[i] = lane_coef[i];
        s2_x_d[i]    = s1_x_q[i];
        s2_prod_d[i] = lane_prod[i];
        s2_b_d[i]    = $signed(s1_coef_q[i][Q_SIZE-1:0]);
        out_data_d[i*Q_SIZE +: Q_SIZE] = lane_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_ENTRIES; i++) lut_q[i] <= LUT_IDENT;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_mask_q   <= '0;
      s2_mask_q   <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < NU_COUNT; i++) begin
        s1_x_q[i]    <= '0;
        s1_coef_q[i] <= '0;
        s2_x_q[i]    <= '0;
        s2_prod_q[i] <= '0;
        s2_b_q[i]    <= '0;
      end
    end else begin
      lut_q       <= lut_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      s1_mask_q   <= s1_mask_d;
      s2_mask_q   <= s2_mask_d;
      out_data_q  <= out_data_d;
      s1_x_q      <= s1_x_d;
      s1_coef_q   <= s1_coef_d;
      s2_x_q      <= s2_x_d;
      s2_prod_q   <= s2_prod_d;
      s2_b_q      <= s2_b_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_act_pwl_unit.sv
// Bench for act_pwl_unit: directed vectors with literal expectations, plus a scoreboard
// fed by an arithmetic model of y = a*x + b with rounding, saturation and bypass.
module tb_act_pwl_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        lut_we = 1'b0;
  logic [5:0]  lut_addr = '0;
  logic [31:0] lut_wdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  act_pwl_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: coefficient table and queue of expected output vectors.
  logic [31:0] mlut [64];
  logic [63:0] expq [$];
  int          n_out = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] data_prev = '0;

  function automatic logic [15:0] pwl(input logic [15:0] x, input logic [31:0] c, input logic m);
    longint a, b, xi, r;
    if (m) return x;
    a  = longint'($signed(c[31:16]));
    b  = longint'($signed(c[15:0]));
    xi = longint'($signed(x));
    r  = ((a * xi + 2048) >>> 12) + b;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [63:0] model_vec(input logic [63:0] d, input logic [3:0] m);
    logic [63:0] r;
    logic [15:0] x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = d[16*i +: 16];
      r[16*i +: 16] = pwl(x, mlut[x[15:10]], m[i]);
    end
    return r;
  endfunction

  // Compare process: inputs are driven 1 time unit after posedge, so the negedge view
  // equals what the next posedge will consume.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      stall_prev = 1'b0;
      for (int i = 0; i < 64; i++) mlut[i] = 32'h1000_0000;
      chk("reset out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset out_data", out_data, 64'd0);
    end else begin
      chk("in_ready rule", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
      if (stall_prev) begin
        chk("stall out_valid", {63'b0, out_valid}, 64'd1);
        chk("stall out_data", out_data, data_prev);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected out_valid", {63'b0, out_valid}, 64'd0);
        end else begin
          chk("scoreboard data", out_data, expq[0]);
          if (out_ready) begin
            $display("out %h", out_data);
            void'(expq.pop_front());
            n_out++;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      if (in_valid && in_ready) begin
        expq.push_back(model_vec(in_data, in_mask));
        $display("in  %h mask %b", in_data, in_mask);
      end
      if (lut_we) mlut[lut_addr] = lut_wdata;
    end
  end

  task automatic lut_wr(input logic [5:0] a, input logic [31:0] w);
    lut_we = 1'b1; lut_addr = a; lut_wdata = w;
    @(posedge clk); #1;
    lut_we = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] m);
    in_valid = 1'b1; in_data = d; in_mask = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts clock edges starting with the accepting edge.
  task automatic run1(input string name, input logic [63:0] d, input logic [3:0] m,
                      input logic [63:0] exp);
    int lat;
    send(d, m);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd3);
    chk({name, " data"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int acc, n0, waitc;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post-reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("post-reset out_data", out_data, 64'd0);
    chk("post-reset in_ready", {63'b0, in_ready}, 64'd1);

    run1("identity", 64'h8000_7FFF_F000_1800, 4'b0000, 64'h8000_7FFF_F000_1800);

    lut_wr(6'd6, 32'h0800_0400);
    run1("linear", 64'h0000_0000_0000_1800, 4'b0000, 64'h0000_0000_0000_1000);
    lut_wr(6'd2, 32'h0001_0000);
    run1("round", 64'h0000_0000_0000_0800, 4'b0000, 64'h0000_0000_0000_0001);

    lut_wr(6'd28, 32'h7FFF_0000);
    lut_wr(6'd32, 32'h7FFF_0000);
    run1("saturate", 64'h0000_0000_8000_7000, 4'b0000, 64'h0000_0000_8000_7FFF);
    run1("mask", 64'h0000_0000_8000_7000, 4'b0001, 64'h0000_0000_8000_7000);

    // -0.5 and -1.5 ties round toward +inf.
    lut_wr(6'd63, 32'h0800_0000);
    run1("neg tie", 64'h0000_0000_FFFF_FFFD, 4'b0000, 64'h0000_0000_0000_FFFF);

    // Backpressure: downstream stalled while the source keeps offering vectors.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = {4{16'(16'h0100 + acc)}};
      in_mask  = 4'b0000;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp accepted", 64'(acc), 64'd3);
    chk("bp in_ready", {63'b0, in_ready}, 64'd0);
    n0 = n_out;
    out_ready = 1'b1;
    waitc = 0;
    while ((expq.size() != 0 || out_valid) && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("bp delivered", 64'(n_out - n0), 64'd3);
    chk("bp drained", {63'b0, out_valid}, 64'd0);

    // Collision: write addr 6 in the same edge that accepts an idx-6 vector.
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_1800; in_mask = 4'b0000;
    lut_we = 1'b1; lut_addr = 6'd6; lut_wdata = 32'h2000_0000;
    @(posedge clk); #1;
    lut_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 10) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("collision old coef", out_data, 64'h0000_0000_0000_1000);
    @(posedge clk); #1;
    chk("collision next valid", {63'b0, out_valid}, 64'd1);
    chk("collision new coef", out_data, 64'h0000_0000_0000_3000);
    @(posedge clk); #1;

    // Reset with three vectors in flight.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = {4{16'(16'h1800 + c)}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight out_valid", {63'b0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", {63'b0, out_valid}, 64'd0);
    chk("midreset out_data", out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("release in_ready", {63'b0, in_ready}, 64'd1);
    run1("identity after reset", {4{16'h1800}}, 4'b0000, {4{16'h1800}});

    repeat (3) @(posedge clk);
    #1;
    chk("final scoreboard empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
